// File: rtl/tone_scheduler.sv
// Fixed-priority arbiter that shares one square-wave tone generator between
// several note requesters, with ms timing, optional pre-emption and a silent gap.
module tone_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int FREQ_W  = 10,
    parameter int DUR_W   = 10,
    parameter int GAP_MS  = 20,
    parameter int PREEMPT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 ticks_per_milli,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*FREQ_W-1:0]   req_freq,
    input  logic [NUM_REQ*DUR_W-1:0]    req_dur,
    input  logic                        mute,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          aborted,
    output logic [FREQ_W-1:0]           freq,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int GW = (GAP_MS > 1) ? $clog2(GAP_MS + 1) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t              state, state_n;
    logic [15:0]         tick_cnt, tick_cnt_n;
    logic [DUR_W-1:0]    remaining, remaining_n;
    logic [GW-1:0]       gap_cnt, gap_cnt_n;
    logic [FREQ_W-1:0]   freq_l, freq_l_n, freq_n;
    logic [NUM_REQ-1:0]  ack_n, done_n, aborted_n;
    logic                busy_n;
    logic [OW-1:0]       owner_n;

    logic [15:0]         tpm_m1;
    logic                ms_tick;
    logic [NUM_REQ-1:0]  elig;
    logic                any_elig;
    logic [OW-1:0]       g;
    logic [FREQ_W-1:0]   g_freq;
    logic [DUR_W-1:0]    g_dur;
    logic                accept;

    // >= rather than == so a shrinking ticks_per_milli still wraps promptly
    assign tpm_m1  = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    assign ms_tick = (tick_cnt >= tpm_m1);

    // A requester is blind for the cycle its ack is visible, so a held req
    // is not counted twice.
    assign elig = req & ~ack;

    always_comb begin
        any_elig = 1'b0;
        g        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                g        = OW'(i);
            end
        end
    end

    assign g_freq = req_freq[int'(g)*FREQ_W +: FREQ_W];
    assign g_dur  = req_dur[int'(g)*DUR_W +: DUR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            freq_l    <= '0;
            ack       <= '0;
            done      <= '0;
            aborted   <= '0;
            freq      <= '0;
            busy      <= 1'b0;
            owner     <= '0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            remaining <= remaining_n;
            gap_cnt   <= gap_cnt_n;
            freq_l    <= freq_l_n;
            ack       <= ack_n;
            done      <= done_n;
            aborted   <= aborted_n;
            freq      <= freq_n;
            busy      <= busy_n;
            owner     <= owner_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        remaining_n = remaining;
        gap_cnt_n   = gap_cnt;
        freq_l_n    = freq_l;
        ack_n       = '0;
        done_n      = '0;
        aborted_n   = '0;
        freq_n      = '0;
        busy_n      = busy;
        owner_n     = owner;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                tick_cnt_n = '0;
                accept     = any_elig;
            end
            PLAY: begin
                tick_cnt_n = ms_tick ? 16'd0 : tick_cnt + 16'd1;
                freq_n     = mute ? '0 : freq_l;
                // completion takes precedence over a same-cycle pre-emption
                if (ms_tick && remaining == DUR_W'(1)) begin
                    freq_n       = '0;
                    remaining_n  = '0;
                    done_n[owner] = 1'b1;
                    if (GAP_MS == 0) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        state_n   = GAP;
                        gap_cnt_n = GW'(GAP_MS);
                    end
                end else if (PREEMPT != 0 && any_elig && g < owner) begin
                    accept           = 1'b1;
                    aborted_n[owner] = 1'b1;
                end else if (ms_tick) begin
                    remaining_n = remaining - DUR_W'(1);
                end
            end
            GAP: begin
                tick_cnt_n = ms_tick ? 16'd0 : tick_cnt + 16'd1;
                if (ms_tick) begin
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt_n = '0;
                        state_n   = IDLE;
                        busy_n    = 1'b0;
                    end else begin
                        gap_cnt_n = gap_cnt - GW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            ack_n[g]    = 1'b1;
            owner_n     = g;
            tick_cnt_n  = '0;
            freq_l_n    = g_freq;
            remaining_n = g_dur;
            // zero-length note: acknowledged and finished at once, never audible
            if (g_dur == '0) begin
                done_n[g] = 1'b1;
                freq_n    = '0;
                state_n   = IDLE;
                busy_n    = 1'b0;
            end else begin
                freq_n  = mute ? '0 : g_freq;
                state_n = PLAY;
                busy_n  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: traces two instances (pre-emptive and not) and
// checks timings derived from note length = dur*max(tpm,1) and gap = GAP_MS ms.
module tb_tone_scheduler;
    localparam int N = 4, FW = 10, DW = 10, GAP = 20, MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       tpm;
    logic [N-1:0]      req, req_b, hold;
    logic [N*FW-1:0]   rfreq;
    logic [N*DW-1:0]   rdur;
    logic              mute;
    logic [N-1:0]      ack, done, aborted, ack_b, done_b, aborted_b;
    logic [FW-1:0]     freq, freq_b;
    logic              busy, busy_b;
    logic [1:0]        owner, owner_b;
    int tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;

    tone_scheduler #(.NUM_REQ(N), .FREQ_W(FW), .DUR_W(DW), .GAP_MS(GAP), .PREEMPT(1)) dut (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req(req), .req_freq(rfreq),
        .req_dur(rdur), .mute(mute), .ack(ack), .done(done), .aborted(aborted),
        .freq(freq), .busy(busy), .owner(owner));

    tone_scheduler #(.NUM_REQ(N), .FREQ_W(FW), .DUR_W(DW), .GAP_MS(GAP), .PREEMPT(0)) dut_np (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req(req_b), .req_freq(rfreq),
        .req_dur(rdur), .mute(mute), .ack(ack_b), .done(done_b), .aborted(aborted_b),
        .freq(freq_b), .busy(busy_b), .owner(owner_b));

    // trace index k holds the outputs registered by the k-th sampled clock edge
    logic [N-1:0]  ack_t[2][MAXC], done_t[2][MAXC], abrt_t[2][MAXC];
    logic [FW-1:0] freq_t[2][MAXC];
    logic          busy_t[2][MAXC];
    logic [1:0]    own_t[2][MAXC];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            ack_t[0][cyc]  <= ack;     ack_t[1][cyc]  <= ack_b;
            done_t[0][cyc] <= done;    done_t[1][cyc] <= done_b;
            abrt_t[0][cyc] <= aborted; abrt_t[1][cyc] <= aborted_b;
            freq_t[0][cyc] <= freq;    freq_t[1][cyc] <= freq_b;
            busy_t[0][cyc] <= busy;    busy_t[1][cyc] <= busy_b;
            own_t[0][cyc]  <= owner;   own_t[1][cyc]  <= owner_b;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [N-1:0] ev(int d, int kind, int k);
        if (kind == 0) return ack_t[d][k];
        if (kind == 1) return done_t[d][k];
        return abrt_t[d][k];
    endfunction

    function automatic int first_ev(int d, int kind, int idx, int from, int to);
        logic [N-1:0] v;
        for (int k = from; k <= to && k < MAXC; k++) begin
            v = ev(d, kind, k);
            if (v[idx] === 1'b1) return k;
        end
        return -1;
    endfunction

    function automatic int count_ev(int d, int kind, int idx, int from, int to);
        int n = 0;
        logic [N-1:0] v;
        for (int k = from; k <= to && k < MAXC; k++) begin
            v = ev(d, kind, k);
            if (idx < 0) n += $countones(v);
            else if (v[idx] === 1'b1) n++;
        end
        return n;
    endfunction

    function automatic int count_freq(int d, int val, int from, int to);
        int n = 0;
        for (int k = from; k <= to && k < MAXC; k++)
            if (freq_t[d][k] === FW'(val)) n++;
        return n;
    endfunction

    function automatic int count_busy(int d, int from, int to);
        int n = 0;
        for (int k = from; k <= to && k < MAXC; k++)
            if (busy_t[d][k] === 1'b1) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // requesters drop req once they see their ack unless held on purpose
    task automatic run(input int n);
        repeat (n) begin
            step();
            req   = req & (~ack | hold);
            req_b = req_b & (~ack_b | hold);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_b = '0; mute = 1'b0; hold = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_note(input int i, input int f, input int du);
        rfreq[i*FW +: FW] = FW'(f);
        rdur[i*DW +: DW]  = DW'(du);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({ack, done, aborted} !== '0) begin
            fails++; $display("FAIL reset_pulses: got %b want 0", {ack, done, aborted});
        end
        tests++;
        if (freq !== '0 || busy !== 1'b0 || owner !== '0) begin
            fails++; $display("FAIL reset_state: freq=%0d busy=%b owner=%0d want 0/0/0", freq, busy, owner);
        end
    endtask

    task automatic test_basic();
        int c;
        do_reset();
        tpm = 16'd2; set_note(1, 262, 5);
        c = cyc; req[1] = 1'b1;
        run(60);
        tests++;
        if (first_ev(0, 0, 1, c, c + 59) !== c + 1) begin
            fails++; $display("FAIL basic_ack: at %0d want %0d", first_ev(0, 0, 1, c, c + 59), c + 1);
        end
        tests++;
        if (count_freq(0, 262, c, c + 59) !== 10) begin
            fails++; $display("FAIL basic_len: %0d cycles want 10", count_freq(0, 262, c, c + 59));
        end
        tests++;
        if (first_ev(0, 1, 1, c, c + 59) !== c + 11) begin
            fails++; $display("FAIL basic_done: at %0d want %0d", first_ev(0, 1, 1, c, c + 59), c + 11);
        end
        tests++;
        if (count_busy(0, c, c + 59) !== 50 || busy_t[0][c + 51] !== 1'b0) begin
            fails++; $display("FAIL basic_busy: %0d cycles want 50", count_busy(0, c, c + 59));
        end
        tests++;
        if (own_t[0][c + 1] !== 2'd1 || own_t[0][c + 55] !== 2'd1) begin
            fails++; $display("FAIL basic_owner: got %0d want 1", own_t[0][c + 55]);
        end
    endtask

    task automatic test_random();
        int c, i, f, du, t, eff, L, w;
        for (int it = 0; it < 6; it++) begin
            t = $urandom_range(0, 3); i = $urandom_range(0, 3);
            f = $urandom_range(1, 1023); du = $urandom_range(1, 8);
            eff = (t == 0) ? 1 : t; L = du * eff; w = L + GAP * eff + 5;
            tpm = 16'(t); set_note(i, f, du);
            c = cyc; req[i] = 1'b1;
            run(w + 1);
            tests++;
            if (first_ev(0, 0, i, c, c + w) !== c + 1 || own_t[0][c + 1] !== 2'(i)) begin
                fails++; $display("FAIL rand_ack[%0d]: at %0d want %0d", i, first_ev(0, 0, i, c, c + w), c + 1);
            end
            tests++;
            if (first_ev(0, 1, i, c, c + w) !== c + 1 + L) begin
                fails++; $display("FAIL rand_done[%0d]: at %0d want %0d", i, first_ev(0, 1, i, c, c + w), c + 1 + L);
            end
            tests++;
            if (count_freq(0, f, c, c + w) !== L) begin
                fails++; $display("FAIL rand_len: %0d cycles want %0d", count_freq(0, f, c, c + w), L);
            end
            tests++;
            if (count_busy(0, c, c + w) !== L + GAP * eff) begin
                fails++; $display("FAIL rand_busy: %0d cycles want %0d", count_busy(0, c, c + w), L + GAP * eff);
            end
        end
    endtask

    task automatic test_preempt();
        int c;
        do_reset();
        tpm = 16'd1; set_note(2, 330, 100); set_note(0, 784, 10);
        hold = 4'b0100;
        c = cyc; req[2] = 1'b1; req_b[2] = 1'b1;
        run(31);
        req[0] = 1'b1; req_b[0] = 1'b1;
        run(140);
        hold = '0;
        tests++;
        if (first_ev(0, 2, 2, c, c + 170) !== c + 32 || first_ev(0, 0, 0, c, c + 170) !== c + 32) begin
            fails++; $display("FAIL pre_abort_ack: abort %0d ack %0d want %0d",
                first_ev(0, 2, 2, c, c + 170), first_ev(0, 0, 0, c, c + 170), c + 32);
        end
        tests++;
        if (count_freq(0, 784, c, c + 170) !== 10 || first_ev(0, 1, 0, c, c + 170) !== c + 42) begin
            fails++; $display("FAIL pre_note0: len %0d done %0d want 10/%0d",
                count_freq(0, 784, c, c + 170), first_ev(0, 1, 0, c, c + 170), c + 42);
        end
        tests++;
        if (first_ev(0, 0, 2, c + 2, c + 170) !== c + 63 || first_ev(0, 1, 2, c, c + 170) !== c + 163) begin
            fails++; $display("FAIL pre_reaccept: ack %0d done %0d want %0d/%0d",
                first_ev(0, 0, 2, c + 2, c + 170), first_ev(0, 1, 2, c, c + 170), c + 63, c + 163);
        end
        tests++;
        if (count_ev(1, 2, -1, c, c + 170) !== 0 || first_ev(1, 1, 2, c, c + 170) !== c + 101) begin
            fails++; $display("FAIL nopre_done: aborts %0d done %0d want 0/%0d",
                count_ev(1, 2, -1, c, c + 170), first_ev(1, 1, 2, c, c + 170), c + 101);
        end
        tests++;
        if (first_ev(1, 0, 0, c, c + 170) !== c + 122) begin
            fails++; $display("FAIL nopre_ack0: at %0d want %0d", first_ev(1, 0, 0, c, c + 170), c + 122);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        tpm = 16'd1; set_note(0, 500, 4); set_note(3, 600, 3);
        c = cyc; req = 4'b1001;
        run(40);
        tests++;
        if (first_ev(0, 0, 0, c, c + 39) !== c + 1 || first_ev(0, 0, 3, c, c + 39) !== c + 26) begin
            fails++; $display("FAIL b2b_acks: ack0 %0d ack3 %0d want %0d/%0d",
                first_ev(0, 0, 0, c, c + 39), first_ev(0, 0, 3, c, c + 39), c + 1, c + 26);
        end
        tests++;
        if (count_ev(0, 0, -1, c, c + 39) !== 2) begin
            fails++; $display("FAIL b2b_single: %0d acks want 2", count_ev(0, 0, -1, c, c + 39));
        end
        tests++;
        if (first_ev(0, 1, 0, c, c + 39) !== c + 5 || first_ev(0, 1, 3, c, c + 39) !== c + 29) begin
            fails++; $display("FAIL b2b_done: done0 %0d done3 %0d want %0d/%0d",
                first_ev(0, 1, 0, c, c + 39), first_ev(0, 1, 3, c, c + 39), c + 5, c + 29);
        end
    endtask

    task automatic test_zero_dur();
        int c;
        do_reset();
        tpm = 16'd2; set_note(1, 262, 0);
        c = cyc; req[1] = 1'b1;
        run(6);
        tests++;
        if (first_ev(0, 0, 1, c, c + 5) !== c + 1 || first_ev(0, 1, 1, c, c + 5) !== c + 1) begin
            fails++; $display("FAIL zero_pulses: ack %0d done %0d want %0d",
                first_ev(0, 0, 1, c, c + 5), first_ev(0, 1, 1, c, c + 5), c + 1);
        end
        tests++;
        if (count_busy(0, c, c + 5) !== 0 || count_freq(0, 0, c, c + 5) !== 6) begin
            fails++; $display("FAIL zero_silent: busy %0d quiet %0d want 0/6",
                count_busy(0, c, c + 5), count_freq(0, 0, c, c + 5));
        end
    endtask

    task automatic test_mute();
        int c;
        do_reset();
        tpm = 16'd2; set_note(1, 196, 6);
        c = cyc; req[1] = 1'b1;
        run(4); mute = 1'b1;
        run(4); mute = 1'b0;
        run(20);
        tests++;
        if (freq_t[0][c + 6] !== '0 || freq_t[0][c + 10] !== FW'(196)) begin
            fails++; $display("FAIL mute_freq: muted %0d resumed %0d want 0/196", freq_t[0][c + 6], freq_t[0][c + 10]);
        end
        tests++;
        if (count_freq(0, 196, c, c + 27) !== 8 || first_ev(0, 1, 1, c, c + 27) !== c + 13) begin
            fails++; $display("FAIL mute_timing: len %0d done %0d want 8/%0d",
                count_freq(0, 196, c, c + 27), first_ev(0, 1, 1, c, c + 27), c + 13);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        tpm = 16'd1; set_note(2, 440, 50);
        c = cyc; req[2] = 1'b1;
        run(10);
        rst = 1'b1; step(); rst = 1'b0;
        tests++;
        if (freq !== '0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrst_state: freq %0d busy %b want 0/0", freq, busy);
        end
        run(60);
        tests++;
        if (count_ev(0, 1, -1, c, c + 69) + count_ev(0, 2, -1, c, c + 69) !== 0) begin
            fails++; $display("FAIL midrst_pulses: %0d done/abort want 0",
                count_ev(0, 1, -1, c, c + 69) + count_ev(0, 2, -1, c, c + 69));
        end
    endtask

    task automatic test_tpm_zero();
        int c;
        do_reset();
        tpm = 16'd0; set_note(3, 100, 3);
        c = cyc; req[3] = 1'b1;
        run(10);
        tests++;
        if (count_freq(0, 100, c, c + 9) !== 3 || first_ev(0, 1, 3, c, c + 9) !== c + 4) begin
            fails++; $display("FAIL tpm0: len %0d done %0d want 3/%0d",
                count_freq(0, 100, c, c + 9), first_ev(0, 1, 3, c, c + 9), c + 4);
        end
    endtask

    initial begin
        tpm = 16'd2; rfreq = '0; rdur = '0; req = '0; req_b = '0; hold = '0; mute = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_preempt();
        test_back_to_back();
        test_zero_dur();
        test_mute();
        test_reset_mid();
        test_tpm_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
